// File: rtl/dmac_arb_pkg.sv
// rtl/dmac_arb_pkg.sv - shared types and defaults for the DMA request arbiter
package dmac_arb_pkg;

  localparam int DMAC_N_CH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ACK    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dmac_rr_picker.sv
// rtl/dmac_rr_picker.sv - combinational rotate-priority pick starting after the last grant
module dmac_rr_picker #(
  parameter int N_CH = 2,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_eligible,
  input  logic [CH_W-1:0] i_last_grant,
  output logic            o_grant_valid,
  output logic [CH_W-1:0] o_grant_idx
);

  // Scan from farthest to nearest so the nearest eligible channel after last_grant wins
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      if (i_eligible[(int'(i_last_grant) + k) % N_CH]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = CH_W'((int'(i_last_grant) + k) % N_CH);
      end
    end
  end

endmodule

// File: rtl/dmac_req_arbiter.sv
// rtl/dmac_req_arbiter.sv - round-robin DMA request arbiter with ack handshake and irq status
module dmac_req_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_CH = DMAC_N_CH,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_dmac_en,
  input  logic [N_CH-1:0] i_dma_req,
  input  logic [N_CH-1:0] i_ch_cfg_valid,
  input  logic [N_CH-1:0] i_ch_irq,
  input  logic [N_CH-1:0] i_irq_clr,
  output logic [N_CH-1:0] o_channel_en,
  output logic [N_CH-1:0] o_dma_ack,
  output logic [CH_W-1:0] o_active_ch,
  output logic            o_busy,
  output logic [N_CH-1:0] o_irq_status,
  output logic            o_irq
);

  localparam logic [N_CH-1:0] L_ONE = {{(N_CH-1){1'b0}}, 1'b1};

  arb_state_t      r_state;
  logic [CH_W-1:0] r_sel;
  logic [CH_W-1:0] r_last_grant;
  logic [N_CH-1:0] r_channel_en;
  logic [N_CH-1:0] r_dma_ack;
  logic [CH_W-1:0] r_active_ch;
  logic            r_busy;
  logic [N_CH-1:0] r_irq_status;
  logic            r_irq;

  logic [N_CH-1:0] w_eligible;
  logic            w_grant_valid;
  logic [CH_W-1:0] w_grant_idx;
  logic [N_CH-1:0] w_grant_onehot;
  logic [N_CH-1:0] w_sel_onehot;
  logic            w_done;
  logic [N_CH-1:0] w_irq_set;
  logic [N_CH-1:0] w_irq_status_nxt;

  // Config valid only matters here, so it is effectively sampled in IDLE
  assign w_eligible     = i_dmac_en ? (i_dma_req & i_ch_cfg_valid) : '0;
  assign w_grant_onehot = L_ONE << w_grant_idx;
  assign w_sel_onehot   = L_ONE << r_sel;

  // Only the owning channel's completion counts; other channels' irq lines are ignored
  assign w_done           = (r_state == ST_ACTIVE) && i_ch_irq[r_sel];
  assign w_irq_set        = w_done ? w_sel_onehot : '0;
  assign w_irq_status_nxt = (r_irq_status & ~i_irq_clr) | w_irq_set;

  dmac_rr_picker #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_picker (
    .i_eligible    (w_eligible),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  // Arbitration FSM with all handshake outputs registered on the state transitions
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_last_grant <= CH_W'(N_CH - 1);
      r_channel_en <= '0;
      r_dma_ack    <= '0;
      r_active_ch  <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_channel_en <= '0;
          r_dma_ack    <= '0;
          if (w_grant_valid) begin
            r_sel        <= w_grant_idx;
            r_active_ch  <= w_grant_idx;
            r_channel_en <= w_grant_onehot;
            r_busy       <= 1'b1;
            r_state      <= ST_GRANT;
          end else begin
            r_active_ch <= '0;
            r_busy      <= 1'b0;
          end
        end
        ST_GRANT: begin
          r_channel_en <= '0;
          r_state      <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (w_done) begin
            r_dma_ack <= w_sel_onehot;
            r_state   <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (!i_dma_req[r_sel]) begin
            r_dma_ack    <= '0;
            r_active_ch  <= '0;
            r_busy       <= 1'b0;
            r_last_grant <= r_sel;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_channel_en <= '0;
          r_dma_ack    <= '0;
          r_active_ch  <= '0;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky completion flags; a set in the same cycle as a clear keeps the bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq_status <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_irq_status <= w_irq_status_nxt;
      r_irq        <= |w_irq_status_nxt;
    end
  end

  assign o_channel_en = r_channel_en;
  assign o_dma_ack    = r_dma_ack;
  assign o_active_ch  = r_active_ch;
  assign o_busy       = r_busy;
  assign o_irq_status = r_irq_status;
  assign o_irq        = r_irq;

endmodule

// File: tb/tb_dmac_req_arbiter.sv
// tb/tb_dmac_req_arbiter.sv - self-checking bench for the DMA request arbiter
module tb_dmac_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic       dmac_en;
  logic [1:0] dma_req;
  logic [1:0] cfg;
  logic [1:0] ch_irq;
  logic [1:0] irq_clr;
  logic [1:0] chen;
  logic [1:0] ack;
  logic       act;
  logic       busy;
  logic [1:0] st;
  logic       irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [1:0] req;
    logic [1:0] cfg;
    logic [1:0] chirq;
    logic [1:0] clr;
    logic [8:0] exp;   // {chen, ack, active_ch, busy, irq_status, irq}
  } vec_t;

  vec_t vecs[$];
  int   sb[$];

  dmac_req_arbiter #(.N_CH(2)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_dmac_en      (dmac_en),
    .i_dma_req      (dma_req),
    .i_ch_cfg_valid (cfg),
    .i_ch_irq       (ch_irq),
    .i_irq_clr      (irq_clr),
    .o_channel_en   (chen),
    .o_dma_ack      (ack),
    .o_active_ch    (act),
    .o_busy         (busy),
    .o_irq_status   (st),
    .o_irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [8:0] outs();
    return {chen, ack, act, busy, st, irq};
  endfunction

  function automatic vec_t mk(input logic en, input logic [1:0] req, input logic [1:0] c,
                              input logic [1:0] ci, input logic [1:0] cl, input logic [8:0] e);
    vec_t v;
    v.en = en; v.req = req; v.cfg = c; v.chirq = ci; v.clr = cl; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Structural invariant: one-hot-or-zero pulses, never channel_en and ack together
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(chen) > 1 || $countones(ack) > 1 || (chen != 2'b00 && ack != 2'b00)) begin
        errors++;
        $display("FAIL onehot: channel_en %b dma_ack %b", chen, ack);
      end
    end
  end

  initial begin
    int exp_ch;
    int n;
    bit found;

    rst_n = 1'b0; dmac_en = 1'b0; dma_req = 2'b00; cfg = 2'b00; ch_irq = 2'b00; irq_clr = 2'b00;
    step(); step();
    chk("reset_state", 32'(outs()), 32'h0);
    rst_n = 1'b1;

    // Vectors: {en, req, cfg, ch_irq, irq_clr} -> {chen, ack, act, busy, st, irq}
    // Single channel, foreign irq ignored, ack hold/release, clear
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, {2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, {2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b10, 2'b00, {2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b01, 2'b00, {2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1}));
    vecs.push_back(mk(1, 2'b01, 2'b01, 2'b00, 2'b00, {2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1}));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b00, {2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1}));
    vecs.push_back(mk(1, 2'b00, 2'b01, 2'b00, 2'b01, {2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0}));
    // Clear racing completion: set wins, then a later clear drops irq
    vecs.push_back(mk(1, 2'b01, 2'b11, 2'b00, 2'b00, {2'b01, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(1, 2'b01, 2'b11, 2'b00, 2'b00, {2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(1, 2'b01, 2'b11, 2'b01, 2'b01, {2'b00, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1}));
    vecs.push_back(mk(1, 2'b00, 2'b11, 2'b00, 2'b01, {2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0}));
    // cfg gating selects ch1; en/req/cfg dropping mid-transfer is ignored; ack with req already low
    vecs.push_back(mk(1, 2'b11, 2'b10, 2'b00, 2'b00, {2'b10, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, {2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b0}));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b10, 2'b00, {2'b00, 2'b10, 1'b1, 1'b1, 2'b10, 1'b1}));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 2'b00, {2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1}));
    vecs.push_back(mk(0, 2'b11, 2'b11, 2'b00, 2'b10, {2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0}));

    for (int i = 0; i < vecs.size(); i++) begin
      dmac_en = vecs[i].en; dma_req = vecs[i].req; cfg = vecs[i].cfg;
      ch_irq = vecs[i].chirq; irq_clr = vecs[i].clr;
      step();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end
    ch_irq = 2'b00; irq_clr = 2'b00;

    // Global enable low: nothing granted for 20 cycles
    dmac_en = 1'b0; dma_req = 2'b11; cfg = 2'b11;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("gate_chen", 32'(chen), 32'h0);
      chk("gate_busy", 32'(busy), 32'h0);
    end

    // Fairness: last grant was ch1, so order must be 0,1,0,1 with immediate re-grant
    sb.push_back(0); sb.push_back(1); sb.push_back(0); sb.push_back(1);
    dmac_en = 1'b1;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      n = 0;
      while (!found && n < 8) begin
        step();
        if (chen != 2'b00) found = 1'b1;
        else n++;
      end
      if (!found || sb.size() == 0) begin
        chk($sformatf("fair_grant%0d_timeout", g), 32'(chen), 32'h1);
        break;
      end
      exp_ch = sb.pop_front();
      chk($sformatf("fair_grant%0d", g), 32'(chen), 32'(2'b01 << exp_ch));
      chk($sformatf("fair_gap%0d", g), 32'(n), 32'h0);
      step();
      ch_irq = 2'(2'b01 << exp_ch);
      step();
      ch_irq = 2'b00;
      chk($sformatf("fair_ack%0d", g), 32'(ack), 32'(2'b01 << exp_ch));
      dma_req = 2'b11 & ~2'(2'b01 << exp_ch);
      step();
      chk($sformatf("fair_idle%0d", g), 32'({ack, busy}), 32'h0);
      dma_req = (g == 3) ? 2'b00 : 2'b11;
    end
    chk("fair_sb_empty", 32'(sb.size()), 32'h0);

    // Reset while ACTIVE: outputs clear asynchronously, pointer returns to "ch0 first"
    step();
    dma_req = 2'b01;
    step();
    step();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'h0);
    step();
    dma_req = 2'b10;
    rst_n = 1'b1;
    step();
    chk("post_reset_ch1", 32'(chen), 32'h2);
    step();
    rst_n = 1'b0;
    step();
    dma_req = 2'b11;
    rst_n = 1'b1;
    step();
    chk("post_reset_ch0_first", 32'(chen), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_req_arbiter.md
Name: dmac_req_arbiter

Overview:
- Upstream request/arbitration stage of the DMA controller; sits between peripheral DMA request lines and the per-channel controllers.
- Picks one eligible requesting channel round-robin and fires a one-cycle channel_en pulse to that channel's controller.
- Waits for that channel's completion irq, then runs a 4-phase ack handshake with the requesting peripheral.
- Keeps sticky per-channel interrupt status; only one channel owns the AHB master at a time.

Parameters:
- N_CH, 2, number of channels / peripheral request lines (≥2).
- CH_W, $clog2(N_CH), width of channel index.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- dmac_en  in  1  global controller enable from config registers
- dma_req  in  N_CH  level request per peripheral, held until acked
- ch_cfg_valid  in  N_CH  channel programmed (src/dst/size valid)
- ch_irq  in  N_CH  completion pulse from each channel controller
- irq_clr  in  N_CH  write-1-to-clear for irq_status
- channel_en  out  N_CH  one-cycle start pulse to the selected channel controller
- dma_ack  out  N_CH  ack to peripheral, 4-phase
- active_ch  out  CH_W  index of the owning channel (valid while busy)
- busy  out  1  high in any state except IDLE
- irq_status  out  N_CH  sticky completion flags
- irq  out  1  OR of irq_status

Behaviour:
- Reset (rst low, async): state=IDLE; last_grant=N_CH-1 so channel 0 wins first. channel_en, dma_ack, active_ch, busy, irq_status and irq all 0.
- eligible = dma_req & ch_cfg_valid, gated by dmac_en.
- IDLE:
  - If eligible != 0, select the first set bit scanning last_grant+1 upward modulo N_CH.
  - Register the selection in sel and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, exactly 1 cycle: channel_en[sel]=1, all other bits 0; go to ACTIVE.
  - The first channel_en pulse appears 1 cycle after the cycle in which the request was sampled.
- ACTIVE:
  - Wait for ch_irq[sel]=1; ch_irq of other channels is ignored.
  - On ch_irq[sel]: set irq_status[sel] and go to ACK.
  - dmac_en falling in ACTIVE does not abort; the running transfer completes.
  - dma_req[sel] dropping early is ignored.
- ACK:
  - dma_ack[sel]=1, registered, from the first ACK cycle.
  - Hold it while dma_req[sel]=1.
  - When dma_req[sel]=0, go to IDLE with dma_ack low in IDLE. Update last_grant=sel on that edge.
  - If dma_req[sel] is already 0 on ACK entry: ack is high for 1 cycle, then IDLE.
- active_ch = sel in GRANT, ACTIVE and ACK; 0 in IDLE. busy = (state != IDLE).
- irq_status:
  - Per bit, next = (cur & ~irq_clr) | set_pulse.
  - A set in the same cycle as a clear wins (bit stays 1).
- irq = |irq_status, registered output, no combinational path from inputs.
- At most one bit of channel_en and of dma_ack is high in any cycle; the two are never high together.
- Back-to-back operation: a request present in the first IDLE cycle after ACK is granted immediately. The minimum gap between grants is 1 IDLE cycle.
- ch_cfg_valid is sampled only in IDLE; deasserting it later has no effect on the running transfer.
- All state and outputs are flops. Unused enum codes recover to IDLE.

Decomposition:
- Package dmac_arb_pkg holds:
  - arb_state_t enum (IDLE, GRANT, ACTIVE, ACK), 2-bit encoding.
  - Localparam defaults for N_CH.
- Sub-module dmac_rr_picker: combinational rotate-priority pick.
  - Inputs: eligible and last_grant.
  - Outputs: grant_valid and grant_idx.
  - Instantiated once; the top holds the FSM, sel/last_grant registers and irq_status.

Test Plan:
- Single channel: N_CH=2, dmac_en=1, cfg_valid=2'b01, req[0] rises at t0.
  - channel_en=2'b01 at t0+1 for 1 cycle.
  - ch_irq[0] pulse → irq_status=01, irq=1, ack[0]=1 from the next cycle.
  - req[0] drops → ack[0] low and IDLE 1 cycle later.
- Fairness: req=2'b11 held continuously, each channel completing.
  - Grant order is ch0, ch1, ch0, ch1.
  - channel_en is never 2'b11.
- Gating:
  - dmac_en=0 with req=11 → no channel_en for 20 cycles, busy=0.
  - cfg_valid=2'b10 with req=2'b11 → only ch1 is granted.
- Ignore foreign irq: while ch0 is ACTIVE, pulse ch_irq[1] → state stays ACTIVE and irq_status[1] stays 0.
- Clear race:
  - irq_clr[0]=1 in the same cycle ch0 completes → irq_status[0]=1.
  - irq_clr[0] 1 cycle later → 0, and irq falls.
- Reset mid-ACTIVE: assert rst low during ACTIVE.
  - All outputs 0 immediately (async).
  - After release with req[1] only, ch1 is granted. With req=11, ch0 is granted first.
